// File: rtl/time_keeper_ctrl_if.sv
// Bundle of the front-end pulses into the time keeper and the time/status
// values it presents to the display driver.
interface time_keeper_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_fmt;
    logic [5:0] hour24;
    logic [6:0] minute;
    logic [6:0] second;
    logic [5:0] hour_disp;
    logic       nAM_PM;
    logic       fmt12;
    logic [1:0] set_state;
    logic       blink;

    // Front end / bench side: drives pulses, observes time.
    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_fmt,
        input  hour24, minute, second, hour_disp, nAM_PM, fmt12, set_state, blink
    );

    // Controller side.
    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_fmt,
        output hour24, minute, second, hour_disp, nAM_PM, fmt12, set_state, blink
    );
endinterface

// File: rtl/time_keeper_ctrl.sv
// BCD time-of-day keeper with button-driven set mode, set-mode timeout,
// field blink and 12/24 h hour presentation.
module time_keeper_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic               clk,
    input  logic               rst,
    time_keeper_ctrl_if.slave  tk
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_TICKS);

    state_t     state_q, state_d;
    logic [5:0] hour_q,  hour_d;
    logic [6:0] min_q,   min_d;
    logic [6:0] sec_q,   sec_d;
    logic       fmt_q,   fmt_d;
    logic       blink_q, blink_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] cnt_inc_s;

    // BCD 00..59 increment with wrap.
    function automatic logic [6:0] bcd_inc60(input logic [6:0] v);
        logic [6:0] r;
        if (v == 7'h59) begin
            r = 7'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD 00..23 increment with wrap.
    function automatic logic [5:0] bcd_inc24(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h23) begin
            r = 6'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[5:4] + 2'd1, 4'd0};
        end else begin
            r = {v[5:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // 24 h BCD hour to 12 h BCD hour (0 -> 12, 13..23 -> 1..11).
    function automatic logic [5:0] to_12h(input logic [5:0] h);
        logic [4:0] b;
        logic [4:0] r;
        logic [4:0] t;
        b = ({3'b000, h[5:4]} * 5'd10) + {1'b0, h[3:0]};
        if (b == 5'd0) begin
            r = 5'd12;
        end else if (b > 5'd12) begin
            r = b - 5'd12;
        end else begin
            r = b;
        end
        t = r - 5'd10;
        if (r >= 5'd10) begin
            return {2'b01, t[3:0]};
        end else begin
            return {2'b00, r[3:0]};
        end
    endfunction

    assign cnt_inc_s = cnt_q + 8'd1;

    // Next-state: FSM, time registers, timeout counter, blink and format.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        fmt_d   = fmt_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;

        if (tk.btn_fmt) begin
            fmt_d = ~fmt_q;
        end else begin
            fmt_d = fmt_q;
        end

        case (state_q)
            ST_RUN: begin
                blink_d = 1'b1;
                cnt_d   = 8'd0;
                // Tick is applied first so that a same-cycle mode press
                // still leaves seconds cleared.
                if (tk.tick_1hz) begin
                    sec_d = bcd_inc60(sec_q);
                    if (sec_q == 7'h59) begin
                        min_d = bcd_inc60(min_q);
                        if (min_q == 7'h59) begin
                            hour_d = bcd_inc24(hour_q);
                        end else begin
                            hour_d = hour_q;
                        end
                    end else begin
                        min_d = min_q;
                    end
                end else begin
                    sec_d = sec_q;
                end
                if (tk.btn_mode) begin
                    state_d = ST_SET_HOUR;
                    sec_d   = 7'h00;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_SET_HOUR, ST_SET_MIN: begin
                if (tk.btn_mode) begin
                    state_d = (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end else if (tk.btn_inc) begin
                    if (state_q == ST_SET_HOUR) begin
                        hour_d = bcd_inc24(hour_q);
                    end else begin
                        min_d = bcd_inc60(min_q);
                    end
                    cnt_d   = 8'd0;
                    blink_d = 1'b1;
                end else if (tk.tick_1hz) begin
                    if (cnt_inc_s >= TIMEOUT_LIM) begin
                        state_d = ST_RUN;
                        cnt_d   = 8'd0;
                        blink_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_inc_s;
                        blink_d = ~blink_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
                blink_d = 1'b1;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            hour_q  <= 6'h00;
            min_q   <= 7'h00;
            sec_q   <= 7'h00;
            fmt_q   <= 1'b0;
            blink_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            fmt_q   <= fmt_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tk.hour24    = hour_q;
    assign tk.minute    = min_q;
    assign tk.second    = sec_q;
    assign tk.fmt12     = fmt_q;
    assign tk.set_state = state_q;
    assign tk.blink     = blink_q;
    assign tk.nAM_PM    = (hour_q >= 6'h12);
    assign tk.hour_disp = fmt_q ? to_12h(hour_q) : hour_q;

endmodule

// File: tb/tb_time_keeper_ctrl.sv
// Directed bench for time_keeper_ctrl: reset, BCD carries, set sequence,
// timeout, 12 h sweep, simultaneous events and mid-set reset.
module tb_time_keeper_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    time_keeper_ctrl_if tk ();

    time_keeper_ctrl #(.TIMEOUT_TICKS(10)) dut (
        .clk (clk),
        .rst (rst),
        .tk  (tk.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One-cycle pulse of the selected inputs, driven and released on negedges.
    task automatic pulse(input logic m, input logic i, input logic t, input logic f);
        @(negedge clk);
        tk.btn_mode = m;
        tk.btn_inc  = i;
        tk.tick_1hz = t;
        tk.btn_fmt  = f;
        @(negedge clk);
        tk.btn_mode = 1'b0;
        tk.btn_inc  = 1'b0;
        tk.tick_1hz = 1'b0;
        tk.btn_fmt  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mode();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int e12;
        tk.btn_mode = 1'b0;
        tk.btn_inc  = 1'b0;
        tk.tick_1hz = 1'b0;
        tk.btn_fmt  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_val("rst_hour",  32'(tk.hour24),    32'h00);
        check_val("rst_min",   32'(tk.minute),    32'h00);
        check_val("rst_sec",   32'(tk.second),    32'h00);
        check_val("rst_fmt",   32'(tk.fmt12),     32'h0);
        check_val("rst_state", 32'(tk.set_state), 32'h0);
        check_val("rst_blink", 32'(tk.blink),     32'h1);
        check_val("rst_disp",  32'(tk.hour_disp), 32'h00);
        check_val("rst_ampm",  32'(tk.nAM_PM),    32'h0);

        // Seconds low-digit carry
        ticks(9);
        check_val("sec_09", 32'(tk.second), 32'h09);
        ticks(1);
        check_val("sec_10", 32'(tk.second), 32'h10);

        // Minute carry from 00:09:59
        mode();
        check_val("entry_sec_clr", 32'(tk.second), 32'h00);
        mode();
        incs(9);
        mode();
        check_val("back_run", 32'(tk.set_state), 32'h0);
        ticks(59);
        check_val("sec_59", 32'(tk.second), 32'h59);
        ticks(1);
        check_val("min_10",    32'(tk.minute), 32'h10);
        check_val("sec_wrap0", 32'(tk.second), 32'h00);

        // Set sequence
        do_reset();
        mode();
        check_val("set_hour_st", 32'(tk.set_state), 32'h1);
        incs(13);
        check_val("hour_13", 32'(tk.hour24), 32'h13);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("fmt12_on", 32'(tk.fmt12),     32'h1);
        check_val("disp_01",  32'(tk.hour_disp), 32'h01);
        check_val("pm_13",    32'(tk.nAM_PM),    32'h1);
        mode();
        check_val("set_min_st", 32'(tk.set_state), 32'h2);
        incs(61);
        check_val("min_01",     32'(tk.minute), 32'h01);
        check_val("hour_kept",  32'(tk.hour24), 32'h13);
        mode();
        check_val("run_st", 32'(tk.set_state), 32'h0);

        // Timeout
        mode();
        ticks(9);
        check_val("to_still_set", 32'(tk.set_state), 32'h1);
        check_val("to_blink_9",   32'(tk.blink),     32'h0);
        check_val("to_no_sec",    32'(tk.second),    32'h00);
        ticks(1);
        check_val("to_run",   32'(tk.set_state), 32'h0);
        check_val("to_hour",  32'(tk.hour24),    32'h13);
        check_val("to_min",   32'(tk.minute),    32'h01);
        check_val("to_sec",   32'(tk.second),    32'h00);
        check_val("to_blink", 32'(tk.blink),     32'h1);

        // Rollover from 23:59:00
        mode();
        incs(10);
        mode();
        incs(58);
        mode();
        check_val("pre_hour", 32'(tk.hour24), 32'h23);
        check_val("pre_min",  32'(tk.minute), 32'h59);
        ticks(59);
        check_val("roll_sec59", 32'(tk.second), 32'h59);
        ticks(1);
        check_val("roll_hour", 32'(tk.hour24),    32'h00);
        check_val("roll_min",  32'(tk.minute),    32'h00);
        check_val("roll_sec",  32'(tk.second),    32'h00);
        check_val("roll_ampm", 32'(tk.nAM_PM),    32'h0);
        check_val("roll_disp", 32'(tk.hour_disp), 32'h12);

        // 12 h sweep over all 24 hours
        mode();
        for (int h = 0; h < 24; h++) begin
            e12 = (h % 12 == 0) ? 12 : (h % 12);
            check_val($sformatf("sw_h24_%0d", h),  32'(tk.hour24),    32'(((h / 10) * 16) + (h % 10)));
            check_val($sformatf("sw_disp_%0d", h), 32'(tk.hour_disp), 32'(((e12 / 10) * 16) + (e12 % 10)));
            check_val($sformatf("sw_ampm_%0d", h), 32'(tk.nAM_PM),    32'(h >= 12));
            incs(1);
        end
        check_val("sw_wrap", 32'(tk.hour24), 32'h00);

        // Simultaneous events
        incs(1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("mi_state", 32'(tk.set_state), 32'h2);
        check_val("mi_hour",  32'(tk.hour24),    32'h01);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("it_min",   32'(tk.minute), 32'h01);
        check_val("it_blink", 32'(tk.blink),  32'h1);
        check_val("it_sec",   32'(tk.second), 32'h00);
        mode();
        ticks(3);
        check_val("run_sec3", 32'(tk.second), 32'h03);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("mt_state", 32'(tk.set_state), 32'h1);
        check_val("mt_sec",   32'(tk.second),    32'h00);
        check_val("mt_min",   32'(tk.minute),    32'h01);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("fmt_off",   32'(tk.fmt12),     32'h0);
        check_val("fmt_disp",  32'(tk.hour_disp), 32'h01);
        check_val("fmt_state", 32'(tk.set_state), 32'h1);

        // Reset during SET_MIN
        mode();
        check_val("pre_rst_st", 32'(tk.set_state), 32'h2);
        do_reset();
        check_val("mr_hour",  32'(tk.hour24),    32'h00);
        check_val("mr_min",   32'(tk.minute),    32'h00);
        check_val("mr_sec",   32'(tk.second),    32'h00);
        check_val("mr_fmt",   32'(tk.fmt12),     32'h0);
        check_val("mr_state", 32'(tk.set_state), 32'h0);
        check_val("mr_blink", 32'(tk.blink),     32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
